apb_req_arbiter: RTL and testbench
==================================

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters sharing the APB UART slave.
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum ACCESS-phase cycles without pready before abort.
REQ-003 SHALL have port pclk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port preset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  in  NREQ  per-requester transfer request.
REQ-006 SHALL have port req_ready  out  NREQ  one-hot acceptance pulse.
REQ-007 SHALL have port req_addr  in  NREQ*12  per-requester byte address.
REQ-008 SHALL have port req_write  in  NREQ  1 = write, 0 = read.
REQ-009 SHALL have port req_wdata  in  NREQ*32  write data.
REQ-010 SHALL have port req_strb  in  NREQ*4  write byte strobes.
REQ-011 SHALL have port rsp_valid  out  NREQ  one-hot, one-cycle completion pulse to the owning requester.
REQ-012 SHALL have port rsp_rdata  out  32  read data, valid with rsp_valid.
REQ-013 SHALL have port rsp_err  out  1  error flag, valid with rsp_valid.
REQ-014 SHALL have APB master ports psel, penable, pwrite (out 1), paddr (out 12), pwdata (out 32), pstrb (out 4), and pready, pslverr (in 1), prdata (in 32).

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-016 In IDLE with any req_valid set, SHALL grant one requester round-robin, starting at index (last_grant+1) mod NREQ, and assert its req_ready for that cycle only.
REQ-017 SHALL register the granted request's addr/write/wdata/strb on the grant edge. If addr[1:0]!=0, it SHALL go to RESP with err=1 and no APB cycle. Otherwise it SHALL go to SETUP.
REQ-018 In SETUP, SHALL drive psel=1 and penable=0 for exactly one cycle, then go to ACCESS.
REQ-019 In ACCESS, SHALL drive psel=1 and penable=1, and hold paddr/pwrite/pwdata/pstrb unchanged from SETUP until pready=1.
REQ-020 On pready=1 in ACCESS, SHALL capture prdata (0 for writes) and pslverr, and go to RESP.
REQ-021 SHALL count ACCESS cycles. When the count reaches TIMEOUT with pready still 0, SHALL go to RESP with err=1 and rdata=0.
REQ-022 In RESP, SHALL pulse rsp_valid for the owner, drive rsp_rdata/rsp_err, and return to IDLE. Arbitration SHALL NOT occur in RESP.
REQ-023 SHALL drive pstrb=0 for reads, and psel=0, penable=0 in IDLE and RESP.
REQ-024 With zero-wait pready, latency from grant to rsp_valid SHALL be 3 cycles, and back-to-back grants SHALL be 4 cycles apart.
REQ-025 SHALL update the round-robin pointer only on a grant. A deasserted req_valid SHALL never be granted. A single active requester SHALL be granted on every IDLE cycle.

Reset
REQ-026 While preset=1 at a rising edge, SHALL enter IDLE and clear psel, penable, pwrite, paddr, pwdata, pstrb, req_ready, rsp_valid, rsp_rdata, rsp_err, the timeout counter and captured data.
REQ-027 On reset, SHALL set last_grant to NREQ-1, so requester 0 has priority first.
REQ-028 Reset during SETUP/ACCESS SHALL abort the transfer with no rsp_valid issued.

Structure
REQ-029 SHALL place the state enum typedef and the constants ADDR_W=12, DATA_W=32 and STRB_W=4 in the shared package apb_arb_pkg.
REQ-030 SHALL place round-robin grant and pointer logic in a sub-module rr_arbiter (NREQ-wide request in, one-hot grant out, advance enable).

Verification
REQ-031 Req0 writes 0x000000A5 to 0x004 with strb 0xF and zero-wait slave -> psel asserted 1 cycle, then psel+penable 1 cycle, then rsp_valid[0]=1 with rsp_err=0, at 3 cycles after req_ready[0].
REQ-032 Req0 and req1 both held valid from reset -> grants alternate 0,1,0,1, and each rsp_valid returns to the matching requester.
REQ-033 Req1 reads 0x008 with the slave returning 0xDEADBEEF after 3 wait states -> APB signals stable throughout, then rsp_rdata=0xDEADBEEF and rsp_err=0.
REQ-034 Slave never asserts pready, TIMEOUT=16 -> psel drops after 16 ACCESS cycles, then rsp_err=1 and rsp_rdata=0.
REQ-035 Misaligned addr 0x006 -> psel never asserted, and rsp_valid arrives with rsp_err=1 one cycle after grant.
REQ-036 preset=1 during ACCESS -> all outputs 0 next cycle, no rsp_valid, and req0 is granted first afterwards.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types and widths for the APB request arbiter.
package apb_arb_pkg;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_t;
endpackage

// File: rtl/apb_req_arbiter_rr.sv
// Round-robin grant selection; the pointer only moves when a grant is taken.
module rr_arbiter #(
    parameter int NREQ = 2,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic [NREQ-1:0]  req,
    input  logic             adv,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx
);
    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] cand;

    // Walk from the farthest candidate to the nearest so the nearest requester wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_q) + k) % NREQ);
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            last_q <= IDX_W'(NREQ - 1);
        end else if (adv) begin
            last_q <= gnt_idx;
        end
    end
endmodule

// File: rtl/apb_req_arbiter.sv
// Multi-requester front end sharing one APB slave, with misalignment and timeout aborts.
//   state     | meaning
//   ST_IDLE   | arbitrate; grant captures the request
//   ST_SETUP  | psel=1, penable=0 for one cycle
//   ST_ACCESS | psel=1, penable=1 until pready or timeout
//   ST_RESP   | one-cycle rsp_valid to the owner
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    input  logic [NREQ*STRB_W-1:0]   req_strb,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic                     psel,
    output logic                     penable,
    output logic                     pwrite,
    output logic [ADDR_W-1:0]        paddr,
    output logic [DATA_W-1:0]        pwdata,
    output logic [STRB_W-1:0]        pstrb,
    input  logic                     pready,
    input  logic                     pslverr,
    input  logic [DATA_W-1:0]        prdata
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_t        state_q, state_d;
    logic [NREQ-1:0]   gnt, owner_q;
    logic [IDX_W-1:0]  gnt_idx;
    logic              grant_en;
    logic [ADDR_W-1:0] gnt_addr, addr_q;
    logic              write_q, err_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic [STRB_W-1:0] strb_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              tmo;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .pclk    (pclk),
        .preset  (preset),
        .req     (req_valid),
        .adv     (grant_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign grant_en = (state_q == ST_IDLE) && (|req_valid) && !preset;
    assign gnt_addr = req_addr[gnt_idx*ADDR_W +: ADDR_W];
    assign tmo      = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (grant_en) state_d = (gnt_addr[1:0] != 2'b00) ? ST_RESP : ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (pready || tmo) state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: if (grant_en) begin
                    owner_q <= gnt;
                    addr_q  <= gnt_addr;
                    write_q <= req_write[gnt_idx];
                    wdata_q <= req_wdata[gnt_idx*DATA_W +: DATA_W];
                    strb_q  <= req_write[gnt_idx] ? req_strb[gnt_idx*STRB_W +: STRB_W] : '0;
                    rdata_q <= '0;
                    err_q   <= (gnt_addr[1:0] != 2'b00);
                end
                ST_SETUP: cnt_q <= CNT_W'(TIMEOUT - 1);
                // pready on the final allowed cycle still completes normally
                ST_ACCESS: begin
                    if (pready) begin
                        rdata_q <= write_q ? '0 : prdata;
                        err_q   <= pslverr;
                    end else if (tmo) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign psel      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign penable   = (state_q == ST_ACCESS);
    assign pwrite    = write_q;
    assign paddr     = addr_q;
    assign pwdata    = wdata_q;
    assign pstrb     = strb_q;
    assign req_ready = grant_en ? gnt : '0;
    assign rsp_valid = (state_q == ST_RESP) ? owner_q : '0;
    assign rsp_rdata = (state_q == ST_RESP) ? rdata_q : '0;
    assign rsp_err   = (state_q == ST_RESP) && err_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Transaction-schedule model of the arbiter plus directed and random stimulus.
module tb_apb_req_arbiter;
    localparam int NREQ = 2;
    localparam int TO   = 16;

    logic              pclk = 1'b0;
    logic              preset;
    logic [NREQ-1:0]   req_valid, req_ready, req_write, rsp_valid;
    logic [NREQ*12-1:0] req_addr;
    logic [NREQ*32-1:0] req_wdata;
    logic [NREQ*4-1:0] req_strb;
    logic [31:0]       rsp_rdata, pwdata, prdata;
    logic              rsp_err, psel, penable, pwrite, pready, pslverr;
    logic [11:0]       paddr;
    logic [3:0]        pstrb;

    apb_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
        .pclk(pclk), .preset(preset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .pslverr(pslverr),
        .prdata(prdata)
    );

    always #5 pclk = ~pclk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a grant fixes the whole schedule of the transfer.
    bit          model_on = 1'b0;
    bit          m_busy = 1'b0, m_misal, m_write, m_err;
    int          m_t, m_end, m_nacc, m_owner;
    int          m_last = NREQ - 1;
    logic [11:0] m_addr;
    logic [31:0] m_wdata, m_rdata;
    logic [3:0]  m_strb;

    // Slave behaviour for the current transfer
    int          s_w = 0, acc_cnt = 0;
    logic [31:0] s_prd = '0;
    bit          s_slverr = 1'b0;
    bit          force_on = 1'b1;
    int          force_w = 0;
    logic [31:0] force_prd = '0;
    bit          force_err = 1'b0;

    logic [NREQ-1:0] obs_ready, obs_rspv;
    logic            obs_psel, obs_pen, obs_pwrite, obs_err;
    logic [11:0]     obs_paddr;
    logic [31:0]     obs_pwdata, obs_rdata;
    logic [3:0]      obs_pstrb;

    function automatic int pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (last + k) % NREQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic step();
        logic [NREQ-1:0] e_ready, e_rspv;
        logic            e_psel, e_pen;
        int              g, tot;
        if (psel === 1'b1 && penable === 1'b1) begin
            pready = (acc_cnt == s_w);
            acc_cnt++;
        end else begin
            pready  = 1'b0;
            acc_cnt = 0;
        end
        pslverr = s_slverr;
        prdata  = pready ? s_prd : $urandom;
        #1;
        obs_ready = req_ready;  obs_rspv  = rsp_valid; obs_psel = psel; obs_pen = penable;
        obs_pwrite = pwrite;    obs_paddr = paddr;     obs_pwdata = pwdata;
        obs_pstrb = pstrb;      obs_rdata = rsp_rdata; obs_err = rsp_err;
        if (model_on) begin
            e_ready = '0; e_rspv = '0; e_psel = 1'b0; e_pen = 1'b0;
            if (!m_busy) begin
                g = pick(req_valid, m_last);
                if (!preset && g >= 0) e_ready[g] = 1'b1;
            end else if (m_t == m_end) begin
                e_rspv[m_owner] = 1'b1;
            end else if (!m_misal) begin
                e_psel = 1'b1;
                e_pen  = (m_t >= 2);
            end
            chk("req_ready", 32'(obs_ready), 32'(e_ready));
            chk("psel", 32'(obs_psel), 32'(e_psel));
            chk("penable", 32'(obs_pen), 32'(e_pen));
            chk("rsp_valid", 32'(obs_rspv), 32'(e_rspv));
            if (e_psel) begin
                chk("paddr", 32'(obs_paddr), 32'(m_addr));
                chk("pwrite", 32'(obs_pwrite), 32'(m_write));
                chk("pwdata", obs_pwdata, m_wdata);
                chk("pstrb", 32'(obs_pstrb), m_write ? 32'(m_strb) : 32'd0);
            end
            if (e_rspv != '0) begin
                chk("rsp_rdata", obs_rdata, m_rdata);
                chk("rsp_err", 32'(obs_err), 32'(m_err));
            end
        end
        if (preset) begin
            m_busy = 1'b0;
            m_last = NREQ - 1;
        end else if (!m_busy) begin
            g = pick(req_valid, m_last);
            if (g >= 0) begin
                m_last  = g;
                m_owner = g;
                m_busy  = 1'b1;
                m_t     = 1;
                m_addr  = req_addr[g*12 +: 12];
                m_write = req_write[g];
                m_wdata = req_wdata[g*32 +: 32];
                m_strb  = req_strb[g*4 +: 4];
                m_misal = (m_addr[1:0] != 2'b00);
                if (force_on) begin
                    s_w = force_w; s_prd = force_prd; s_slverr = force_err;
                end else begin
                    s_w = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 25) : $urandom_range(0, 3);
                    s_prd = $urandom;
                    s_slverr = ($urandom_range(0, 7) == 0);
                end
                tot     = s_w + 1;
                m_nacc  = (tot > TO) ? TO : tot;
                m_end   = m_misal ? 1 : 2 + m_nacc;
                m_err   = m_misal || (tot > TO) || s_slverr;
                m_rdata = (m_misal || (tot > TO) || m_write) ? 32'd0 : s_prd;
            end
        end else if (m_t == m_end) begin
            m_busy = 1'b0;
        end else begin
            m_t++;
        end
        @(negedge pclk);
    endtask

    task automatic set_req(input int i, input logic [11:0] a, input bit w,
                           input logic [31:0] d, input logic [3:0] s);
        req_valid[i] = 1'b1;
        req_addr[i*12 +: 12] = a;
        req_write[i] = w;
        req_wdata[i*32 +: 32] = d;
        req_strb[i*4 +: 4] = s;
    endtask

    int gq[$];
    int rq[$];
    int cnt;
    bit seen;
    logic [31:0] cap_rdata;
    logic        cap_err;

    initial begin
        preset = 1'b1; req_valid = '0; req_addr = '0; req_write = '0;
        req_wdata = '0; req_strb = '0; pready = 1'b0; pslverr = 1'b0; prdata = '0;
        step();
        model_on = 1'b1;
        step();
        preset = 1'b0;
        step();
        chk("rst_psel", 32'(obs_psel), 32'd0);
        chk("rst_rsp_valid", 32'(obs_rspv), 32'd0);
        chk("rst_rsp_err", 32'(obs_err), 32'd0);

        // single zero-wait write from requester 0
        force_w = 0; force_prd = 32'h1234_5678; force_err = 1'b0;
        set_req(0, 12'h004, 1'b1, 32'h0000_00A5, 4'hF);
        step();
        chk("t1_ready", 32'(obs_ready), 32'h1);
        req_valid = '0;
        step();
        chk("t1_setup_psel", 32'(obs_psel), 32'd1);
        chk("t1_setup_pen", 32'(obs_pen), 32'd0);
        step();
        chk("t1_access_pen", 32'(obs_pen), 32'd1);
        chk("t1_pwdata", obs_pwdata, 32'h0000_00A5);
        chk("t1_pstrb", 32'(obs_pstrb), 32'hF);
        step();
        chk("t1_rsp_valid", 32'(obs_rspv), 32'h1);
        chk("t1_rsp_err", 32'(obs_err), 32'd0);
        step();

        // both requesters held valid: alternating grants four cycles apart
        preset = 1'b1; step(); preset = 1'b0;
        set_req(0, 12'h010, 1'b0, 32'h0, 4'h0);
        set_req(1, 12'h020, 1'b0, 32'h0, 4'h0);
        for (int k = 0; k < 16; k++) begin
            step();
            if (obs_ready != '0) gq.push_back(obs_ready[1] ? 1 : 0);
            if (obs_rspv != '0) rq.push_back(obs_rspv[1] ? 1 : 0);
        end
        req_valid = '0;
        chk("t2_ngrant", gq.size(), 4);
        chk("t2_nrsp", rq.size(), 4);
        for (int k = 0; k < gq.size() && k < 4; k++) chk("t2_grant_order", gq[k], k % 2);
        for (int k = 0; k < rq.size() && k < 4; k++) chk("t2_rsp_owner", rq[k], k % 2);

        // read with three wait states
        force_w = 3; force_prd = 32'hDEAD_BEEF; force_err = 1'b0;
        set_req(1, 12'h008, 1'b0, 32'h5555_0000, 4'hA);
        step();
        req_valid = '0;
        cnt = 0; seen = 1'b0; cap_rdata = '0; cap_err = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            step();
            if (obs_psel) begin
                cnt++;
                chk("t3_paddr", 32'(obs_paddr), 32'h008);
                chk("t3_pstrb", 32'(obs_pstrb), 32'h0);
            end
            if (obs_rspv == 2'b10) begin
                seen = 1'b1; cap_rdata = obs_rdata; cap_err = obs_err;
            end
        end
        chk("t3_rsp_seen", 32'(seen), 32'd1);
        chk("t3_psel_cycles", cnt, 5);
        chk("t3_rdata", cap_rdata, 32'hDEAD_BEEF);
        chk("t3_err", 32'(cap_err), 32'd0);

        // silent slave: timeout abort
        force_w = 99; force_prd = 32'hCAFE_F00D;
        set_req(0, 12'h010, 1'b0, 32'h0, 4'h0);
        step();
        req_valid = '0;
        cnt = 0; seen = 1'b0; cap_rdata = 32'hFFFF_FFFF; cap_err = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            step();
            if (obs_pen) cnt++;
            if (obs_rspv == 2'b01) begin
                seen = 1'b1; cap_rdata = obs_rdata; cap_err = obs_err;
            end
        end
        chk("t4_rsp_seen", 32'(seen), 32'd1);
        chk("t4_access_cycles", cnt, TO);
        chk("t4_err", 32'(cap_err), 32'd1);
        chk("t4_rdata", cap_rdata, 32'd0);

        // misaligned address: no bus cycle, error next cycle
        set_req(0, 12'h006, 1'b1, 32'h1, 4'hF);
        step();
        chk("t5_ready", 32'(obs_ready), 32'h1);
        req_valid = '0;
        step();
        chk("t5_psel", 32'(obs_psel), 32'd0);
        chk("t5_rsp_valid", 32'(obs_rspv), 32'h1);
        chk("t5_err", 32'(obs_err), 32'd1);

        // reset in the middle of ACCESS
        set_req(1, 12'h00C, 1'b1, 32'h7777_7777, 4'h3);
        step();
        req_valid = '0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            step();
            if (obs_pen) seen = 1'b1;
        end
        chk("t6_access_seen", 32'(seen), 32'd1);
        preset = 1'b1;
        set_req(0, 12'h014, 1'b0, 32'h0, 4'h0);
        set_req(1, 12'h018, 1'b0, 32'h0, 4'h0);
        step();
        preset = 1'b0;
        req_valid = '0;
        step();
        chk("t6_psel", 32'(obs_psel), 32'd0);
        chk("t6_pen", 32'(obs_pen), 32'd0);
        chk("t6_pwrite", 32'(obs_pwrite), 32'd0);
        chk("t6_paddr", 32'(obs_paddr), 32'd0);
        chk("t6_pwdata", obs_pwdata, 32'd0);
        chk("t6_pstrb", 32'(obs_pstrb), 32'd0);
        chk("t6_rsp_valid", 32'(obs_rspv), 32'd0);
        chk("t6_rsp_err", 32'(obs_err), 32'd0);
        req_valid = 2'b11;
        step();
        chk("t6_first_grant", 32'(obs_ready), 32'h1);

        // randomized traffic
        force_on = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            preset = ($urandom_range(0, 299) == 0);
            req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                req_addr[i*12 +: 12] = ($urandom_range(0, 5) == 0) ? 12'($urandom)
                                                                    : {10'($urandom), 2'b00};
                req_write[i] = $urandom_range(0, 1) == 1;
                req_wdata[i*32 +: 32] = $urandom;
                req_strb[i*4 +: 4] = 4'($urandom);
            end
            step();
        end
        req_valid = '0;
        preset = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
